// File: rtl/hazard3_sba_pkg.sv
// Shared constants for the debug-module System Bus Access controller:
// register indices, sbcs field positions, error codes and FSM states.
package hazard3_sba_pkg;

  localparam logic [1:0] REG_SBCS       = 2'd0;
  localparam logic [1:0] REG_SBADDRESS0 = 2'd1;
  localparam logic [1:0] REG_SBDATA0    = 2'd2;

  localparam int SBCS_SBVERSION_LSB  = 29;
  localparam int SBCS_SBBUSYERROR    = 22;
  localparam int SBCS_SBBUSY         = 21;
  localparam int SBCS_SBREADONADDR   = 20;
  localparam int SBCS_SBACCESS_LSB   = 17;
  localparam int SBCS_SBAUTOINC      = 16;
  localparam int SBCS_SBREADONDATA   = 15;
  localparam int SBCS_SBERROR_LSB    = 12;
  localparam int SBCS_SBASIZE_LSB    = 5;
  localparam int SBCS_SBACC_SUPP_LSB = 0;

  localparam logic [2:0] SBVERSION = 3'd1;

  localparam logic [2:0] SBERR_NONE  = 3'd0;
  localparam logic [2:0] SBERR_BUS   = 3'd2;
  localparam logic [2:0] SBERR_ALIGN = 3'd3;
  localparam logic [2:0] SBERR_SIZE  = 3'd4;

  localparam logic [2:0] SBACCESS_8  = 3'd0;
  localparam logic [2:0] SBACCESS_16 = 3'd1;
  localparam logic [2:0] SBACCESS_32 = 3'd2;

  typedef enum logic {
    S_IDLE,
    S_BUS
  } sba_state_t;

endpackage

// File: rtl/hazard3_sbus_lanes.sv
// Byte-lane handling for SBA: replicate narrow write data across the word,
// and right-justify/mask narrow read data using the low address bits.
module hazard3_sbus_lanes
  import hazard3_sba_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [31:0] wdata_in,
  output logic [31:0] wdata_rep,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_addr_lo,
  input  logic [31:0] rdata_in,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_shifted;

  assign rdata_shifted = rdata_in >> {rd_addr_lo, 3'b000};

  always_comb begin
    case (wr_size)
      SBACCESS_8[1:0]:  wdata_rep = {4{wdata_in[7:0]}};
      SBACCESS_16[1:0]: wdata_rep = {2{wdata_in[15:0]}};
      default:          wdata_rep = wdata_in;
    endcase
  end

  always_comb begin
    case (rd_size)
      SBACCESS_8[1:0]:  rdata_ext = {24'h0, rdata_shifted[7:0]};
      SBACCESS_16[1:0]: rdata_ext = {16'h0, rdata_shifted[15:0]};
      default:          rdata_ext = rdata_shifted;
    endcase
  end

endmodule

// File: rtl/hazard3_sbus_ctrl.sv
// Debug Module System Bus Access controller: sbcs/sbaddress0/sbdata0 and a
// single-transfer master on the dbg_sbus port, clocked by clk_always_on.
module hazard3_sbus_ctrl
  import hazard3_sba_pkg::*;
#(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk_always_on,
  input  logic              rst_n,
  input  logic              dmactive,
  input  logic              reg_wen,
  input  logic              reg_ren,
  input  logic [1:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic [W_ADDR-1:0] sbus_addr,
  output logic              sbus_write,
  output logic [1:0]        sbus_size,
  output logic              sbus_vld,
  input  logic              sbus_rdy,
  input  logic              sbus_err,
  output logic [W_DATA-1:0] sbus_wdata,
  input  logic [W_DATA-1:0] sbus_rdata
);

  sba_state_t        state, state_nxt;
  logic [W_ADDR-1:0] sbaddress0;
  logic [31:0]       sbdata0;
  logic [2:0]        sbaccess, sberror;
  logic              sbautoincrement, sbreadonaddr, sbreadondata, sbbusyerror;
  logic              discard;

  logic              busy, wr_sbcs, wr_addr, wr_data, rd_data, busy_viol;
  logic              trig, size_err, align_err, start, complete;
  logic [W_ADDR-1:0] trig_addr;
  logic [W_DATA-1:0] wdata_rep, rdata_ext;

  assign busy      = state == S_BUS;
  assign wr_sbcs   = reg_wen && reg_addr == REG_SBCS;
  assign wr_addr   = reg_wen && reg_addr == REG_SBADDRESS0;
  assign wr_data   = reg_wen && reg_addr == REG_SBDATA0;
  assign rd_data   = reg_ren && reg_addr == REG_SBDATA0;
  assign busy_viol = busy && (wr_addr || wr_data || rd_data);

  // Pending errors suppress new triggers but not the register writes themselves.
  assign trig = !busy && dmactive && sberror == SBERR_NONE && !sbbusyerror &&
                (wr_data || (wr_addr && sbreadonaddr) || (rd_data && sbreadondata));
  assign trig_addr = wr_addr ? reg_wdata[W_ADDR-1:0] : sbaddress0;
  assign size_err  = sbaccess > SBACCESS_32;
  assign align_err = (sbaccess == SBACCESS_16 && trig_addr[0]) ||
                     (sbaccess == SBACCESS_32 && trig_addr[1:0] != 2'b00);
  assign start     = trig && !size_err && !align_err;
  assign complete  = busy && sbus_rdy;
  assign sbus_vld  = busy;

  hazard3_sbus_lanes u_lanes (
    .wr_size    (sbaccess[1:0]),
    .wdata_in   (reg_wdata),
    .wdata_rep  (wdata_rep),
    .rd_size    (sbus_size),
    .rd_addr_lo (sbus_addr[1:0]),
    .rdata_in   (sbus_rdata),
    .rdata_ext  (rdata_ext)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_always_on or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)    state_nxt = S_BUS;
      S_BUS:   if (sbus_rdy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The request is frozen for the whole data phase, including across dmactive=0.
  always_ff @(posedge clk_always_on or negedge rst_n) begin
    if (!rst_n) begin
      sbus_addr  <= '0;
      sbus_write <= 1'b0;
      sbus_size  <= 2'd0;
      sbus_wdata <= '0;
    end else if (start) begin
      sbus_addr  <= trig_addr;
      sbus_write <= wr_data;
      sbus_size  <= sbaccess[1:0];
      sbus_wdata <= wdata_rep;
    end
  end

  always_ff @(posedge clk_always_on or negedge rst_n) begin
    if (!rst_n) begin
      sbaddress0      <= '0;
      sbdata0         <= '0;
      sbaccess        <= SBACCESS_32;
      sbautoincrement <= 1'b0;
      sbreadonaddr    <= 1'b0;
      sbreadondata    <= 1'b0;
      sberror         <= SBERR_NONE;
      sbbusyerror     <= 1'b0;
      discard         <= 1'b0;
    end else begin
      if (complete)
        discard <= 1'b0;
      else if (!dmactive && busy)
        discard <= 1'b1;

      if (!dmactive) begin
        sbaddress0      <= '0;
        sbdata0         <= '0;
        sbaccess        <= SBACCESS_32;
        sbautoincrement <= 1'b0;
        sbreadonaddr    <= 1'b0;
        sbreadondata    <= 1'b0;
        sberror         <= SBERR_NONE;
        sbbusyerror     <= 1'b0;
      end else begin
        if (wr_sbcs) begin
          sbreadonaddr    <= reg_wdata[SBCS_SBREADONADDR];
          sbaccess        <= reg_wdata[SBCS_SBACCESS_LSB +: 3];
          sbautoincrement <= reg_wdata[SBCS_SBAUTOINC];
          sbreadondata    <= reg_wdata[SBCS_SBREADONDATA];
          sberror         <= sberror & ~reg_wdata[SBCS_SBERROR_LSB +: 3];
          sbbusyerror     <= sbbusyerror & ~reg_wdata[SBCS_SBBUSYERROR];
        end

        if (busy_viol) begin
          sbbusyerror <= 1'b1;
        end else begin
          if (wr_addr) sbaddress0 <= reg_wdata[W_ADDR-1:0];
          if (wr_data) sbdata0    <= reg_wdata;
        end

        if (trig && size_err)
          sberror <= SBERR_SIZE;
        else if (trig && align_err)
          sberror <= SBERR_ALIGN;

        if (complete && !discard) begin
          if (sbus_err) begin
            sberror <= SBERR_BUS;
          end else begin
            if (!sbus_write)
              sbdata0 <= rdata_ext;
            if (sbautoincrement)
              sbaddress0 <= sbaddress0 + (W_ADDR'(1) << sbus_size);
          end
        end
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_SBCS: begin
        reg_rdata[SBCS_SBVERSION_LSB +: 3]  = SBVERSION;
        reg_rdata[SBCS_SBBUSYERROR]         = sbbusyerror;
        reg_rdata[SBCS_SBBUSY]              = busy;
        reg_rdata[SBCS_SBREADONADDR]        = sbreadonaddr;
        reg_rdata[SBCS_SBACCESS_LSB +: 3]   = sbaccess;
        reg_rdata[SBCS_SBAUTOINC]           = sbautoincrement;
        reg_rdata[SBCS_SBREADONDATA]        = sbreadondata;
        reg_rdata[SBCS_SBERROR_LSB +: 3]    = sberror;
        reg_rdata[SBCS_SBASIZE_LSB +: 7]    = 7'(W_ADDR);
        reg_rdata[SBCS_SBACC_SUPP_LSB +: 3] = 3'b111;
      end
      REG_SBADDRESS0: reg_rdata = 32'(sbaddress0);
      REG_SBDATA0:    reg_rdata = sbdata0;
      default:        reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hazard3_sbus_ctrl.sv
// Self-checking bench for hazard3_sbus_ctrl: a bus responder pops expected
// transfers from a scoreboard queue and checks every request it completes.
module tb_hazard3_sbus_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk_always_on, rst_n, dmactive;
  logic        reg_wen, reg_ren;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [31:0] sbus_addr, sbus_wdata, sbus_rdata;
  logic        sbus_write, sbus_vld, sbus_rdy, sbus_err;
  logic [1:0]  sbus_size;

  xfer_t       sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          xfers   = 0;
  int          rdy_delay = 0;
  logic        resp_err = 1'b0;
  logic [31:0] resp_rdata = '0;

  hazard3_sbus_ctrl #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk_always_on (clk_always_on),
    .rst_n         (rst_n),
    .dmactive      (dmactive),
    .reg_wen       (reg_wen),
    .reg_ren       (reg_ren),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .sbus_addr     (sbus_addr),
    .sbus_write    (sbus_write),
    .sbus_size     (sbus_size),
    .sbus_vld      (sbus_vld),
    .sbus_rdy      (sbus_rdy),
    .sbus_err      (sbus_err),
    .sbus_wdata    (sbus_wdata),
    .sbus_rdata    (sbus_rdata)
  );

  initial clk_always_on = 1'b0;
  always #5 clk_always_on = ~clk_always_on;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sbcs_val(input logic bbe, input logic busy, input logic roa,
                                           input logic [2:0] acc, input logic ai, input logic rod,
                                           input logic [2:0] err);
    return {3'd1, 6'd0, bbe, busy, roa, acc, ai, rod, err, 7'd32, 2'd0, 3'b111};
  endfunction

  task automatic push_xfer(input logic [31:0] a, input logic w, input logic [1:0] s,
                           input logic [31:0] d);
    xfer_t e;
    e.addr = a; e.write = w; e.size = s; e.wdata = d;
    sb.push_back(e);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_always_on);
    reg_wen = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk_always_on); #1;
    reg_wen = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk_always_on);
    reg_ren = 1'b1; reg_addr = a;
    #1 d = reg_rdata;
    @(posedge clk_always_on); #1;
    reg_ren = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_always_on);
      if (!sbus_vld) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({tag, "_idle_timeout"}, 32'(done), 32'd1);
  endtask

  // Bus responder: holds rdy low for rdy_delay cycles of vld, then completes.
  initial begin : responder
    int    wait_cnt;
    logic  rdy_prev;
    xfer_t e;
    wait_cnt   = 0;
    sbus_rdy   = 1'b0;
    sbus_err   = 1'b0;
    sbus_rdata = '0;
    forever begin
      @(negedge clk_always_on);
      rdy_prev = sbus_rdy;
      sbus_rdy = 1'b0;
      sbus_err = 1'b0;
      if (rdy_prev) begin
        check("vld_drop_after_rdy", 32'(sbus_vld), 32'd0);
        wait_cnt = 0;
      end else begin
        if (wait_cnt > 0) begin
          check("vld_hold_until_rdy", 32'(sbus_vld), 32'd1);
          if (!sbus_vld) wait_cnt = 0;
        end
        if (sbus_vld) begin
          if (wait_cnt == rdy_delay) begin
            check("xfer_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("xfer_addr", sbus_addr, e.addr);
              check("xfer_write", 32'(sbus_write), 32'(e.write));
              check("xfer_size", 32'(sbus_size), 32'(e.size));
              if (e.write) check("xfer_wdata", sbus_wdata, e.wdata);
            end
            xfers++;
            sbus_rdy   = 1'b1;
            sbus_err   = resp_err;
            sbus_rdata = resp_rdata;
          end else begin
            wait_cnt++;
            sbus_err = resp_err;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int xf0;
    rst_n = 1'b0; dmactive = 1'b1;
    reg_wen = 1'b0; reg_ren = 1'b0; reg_addr = 2'd0; reg_wdata = '0;
    repeat (3) @(negedge clk_always_on);
    check("rst_vld", 32'(sbus_vld), 32'd0);
    check("rst_addr", sbus_addr, 32'd0);
    rst_n = 1'b1;

    read_check("rst_sbcs", 2'd0, sbcs_val(0, 0, 0, 3'd2, 0, 0, 3'd0));
    read_check("rst_sbaddress0", 2'd1, 32'd0);
    read_check("rst_sbdata0", 2'd2, 32'd0);
    read_check("rsvd_reg", 2'd3, 32'd0);

    // Word write, one-cycle vld latency, sbbusy visible mid-transfer.
    rdy_delay = 1;
    reg_write(2'd1, 32'h2000_0004);
    check("t1_vld_pre", 32'(sbus_vld), 32'd0);
    push_xfer(32'h2000_0004, 1'b1, 2'd2, 32'hDEAD_BEEF);
    reg_write(2'd2, 32'hDEAD_BEEF);
    check("t1_vld_next", 32'(sbus_vld), 32'd1);
    read_check("t1_sbcs_busy", 2'd0, sbcs_val(0, 1, 0, 3'd2, 0, 0, 3'd0));
    wait_idle("t1");
    read_check("t1_sbcs_idle", 2'd0, sbcs_val(0, 0, 0, 3'd2, 0, 0, 3'd0));
    read_check("t1_sbdata0", 2'd2, 32'hDEAD_BEEF);

    // Read on address write: byte at offset 3, then halfword at offset 2.
    rdy_delay = 0;
    resp_rdata = 32'hAABB_CCDD;
    reg_write(2'd0, 32'h0010_0000);
    push_xfer(32'h0000_0103, 1'b0, 2'd0, 32'h0);
    reg_write(2'd1, 32'h0000_0103);
    wait_idle("t2a");
    read_check("t2_byte_rdata", 2'd2, 32'h0000_00AA);
    reg_write(2'd0, 32'h0012_0000);
    push_xfer(32'h0000_0202, 1'b0, 2'd1, 32'h0);
    reg_write(2'd1, 32'h0000_0202);
    wait_idle("t2b");
    read_check("t2_half_rdata", 2'd2, 32'h0000_AABB);

    // Read on data read: old sbdata0 comes back first, then the new word lands.
    reg_write(2'd0, 32'h0004_8000);
    reg_write(2'd1, 32'h0000_0204);
    resp_rdata = 32'h0102_0304;
    push_xfer(32'h0000_0204, 1'b0, 2'd2, 32'h0);
    read_check("t2_rod_old", 2'd2, 32'h0000_AABB);
    wait_idle("t2c");
    reg_write(2'd0, 32'h0004_0000);
    read_check("t2_rod_new", 2'd2, 32'h0102_0304);

    // Halfword autoincrement with lane replication.
    reg_write(2'd0, 32'h0003_0000);
    reg_write(2'd1, 32'h0000_1000);
    for (int i = 0; i < 3; i++) begin
      push_xfer(32'h0000_1000 + 32'(2 * i), 1'b1, 2'd1, 32'h1234_1234);
      reg_write(2'd2, 32'h0000_1234);
      wait_idle("t3");
    end
    read_check("t3_autoinc_addr", 2'd1, 32'h0000_1006);

    // Alignment, size and bus errors; W1C clearing.
    xf0 = xfers;
    reg_write(2'd0, 32'h0002_0000);
    reg_write(2'd1, 32'h0000_1001);
    reg_write(2'd2, 32'h0000_0055);
    repeat (2) @(negedge clk_always_on);
    read_check("t4_align_err", 2'd0, sbcs_val(0, 0, 0, 3'd1, 0, 0, 3'd3));
    reg_write(2'd0, 32'h0002_7000);
    read_check("t4_w1c", 2'd0, sbcs_val(0, 0, 0, 3'd1, 0, 0, 3'd0));
    reg_write(2'd0, 32'h000A_0000);
    reg_write(2'd2, 32'h0000_0066);
    repeat (2) @(negedge clk_always_on);
    read_check("t4_size_err", 2'd0, sbcs_val(0, 0, 0, 3'd5, 0, 0, 3'd4));
    check("t4_no_xfer", 32'(xfers - xf0), 32'd0);
    reg_write(2'd0, 32'h0005_7000);
    reg_write(2'd1, 32'h0000_3000);
    rdy_delay = 1;
    resp_err = 1'b1;
    push_xfer(32'h0000_3000, 1'b1, 2'd2, 32'h1111_1111);
    reg_write(2'd2, 32'h1111_1111);
    wait_idle("t4");
    resp_err = 1'b0;
    read_check("t4_bus_err", 2'd0, sbcs_val(0, 0, 0, 3'd2, 1, 0, 3'd2));
    read_check("t4_no_autoinc", 2'd1, 32'h0000_3000);
    reg_write(2'd0, 32'h0004_7000);
    read_check("t4_cleared", 2'd0, sbcs_val(0, 0, 0, 3'd2, 0, 0, 3'd0));

    // Busy violation: second sbdata0 write during a stalled transfer.
    xf0 = xfers;
    rdy_delay = 5;
    reg_write(2'd1, 32'h0000_4000);
    push_xfer(32'h0000_4000, 1'b1, 2'd2, 32'hCAFE_F00D);
    reg_write(2'd2, 32'hCAFE_F00D);
    reg_write(2'd2, 32'h0BAD_BAD0);
    wait_idle("t5");
    repeat (3) @(negedge clk_always_on);
    read_check("t5_busyerr", 2'd0, sbcs_val(1, 0, 0, 3'd2, 0, 0, 3'd0));
    read_check("t5_sbdata0", 2'd2, 32'hCAFE_F00D);
    check("t5_one_xfer", 32'(xfers - xf0), 32'd1);
    reg_write(2'd0, 32'h0044_0000);
    read_check("t5_busyerr_clr", 2'd0, sbcs_val(0, 0, 0, 3'd2, 0, 0, 3'd0));

    // dmactive dropped mid-read: request held to rdy, result discarded.
    rdy_delay = 3;
    resp_rdata = 32'h1234_5678;
    reg_write(2'd0, 32'h0014_0000);
    push_xfer(32'h0000_5000, 1'b0, 2'd2, 32'h0);
    reg_write(2'd1, 32'h0000_5000);
    @(negedge clk_always_on);
    dmactive = 1'b0;
    wait_idle("t6");
    read_check("t6_sbcs_reset", 2'd0, sbcs_val(0, 0, 0, 3'd2, 0, 0, 3'd0));
    read_check("t6_sbdata0_discard", 2'd2, 32'd0);
    xf0 = xfers;
    reg_write(2'd2, 32'h0000_0077);
    repeat (4) @(negedge clk_always_on);
    check("t6_blocked", 32'(xfers - xf0), 32'd0);
    dmactive = 1'b1;
    read_check("t6_sbdata0_after", 2'd2, 32'd0);
    read_check("t6_sbaddress0_after", 2'd1, 32'd0);
    read_check("t6_sbcs_after", 2'd0, sbcs_val(0, 0, 0, 3'd2, 0, 0, 3'd0));

    repeat (2) @(negedge clk_always_on);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard3_sbus_ctrl.md
Name: hazard3_sbus_ctrl

Overview:
RISC-V Debug Module System Bus Access (SBA) controller: implements sbcs, sbaddress0 and sbdata0, and turns debugger register accesses into single transfers on the core's dbg_sbus_* master interface, which the single-port arbiter muxes onto AHB5.
Sits directly upstream of the arbiter's sbus port, inside the debug module, on clk_always_on, so SBA works while the core is clock-gated.

Parameters:
W_ADDR, 32, system bus address width; also reported in sbcs.sbasize.
W_DATA, 32, bus data width; must be 32.

Ports:
clk_always_on  in  1  free-running clock
rst_n  in  1  asynchronous active-low reset
dmactive  in  1  dmcontrol.dmactive; low = synchronous soft reset of SBA state
reg_wen  in  1  single-cycle register write strobe
reg_ren  in  1  single-cycle register read strobe; only side-effects depend on it
reg_addr  in  2  0=sbcs, 1=sbaddress0, 2=sbdata0, 3=reserved (reads 0, writes ignored)
reg_wdata  in  32  register write data
reg_rdata  out  32  combinational read data for reg_addr
sbus_addr  out  W_ADDR  to dbg_sbus_addr
sbus_write  out  1  to dbg_sbus_write
sbus_size  out  2  to dbg_sbus_size (sbaccess[1:0])
sbus_vld  out  1  to dbg_sbus_vld
sbus_rdy  in  1  dbg_sbus_rdy: data phase complete
sbus_err  in  1  dbg_sbus_err: bus error response
sbus_wdata  out  W_DATA  to dbg_sbus_wdata, lane-replicated
sbus_rdata  in  W_DATA  dbg_sbus_rdata

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk_always_on.
- Reset values: sbus_vld=0, sbus_write=0, sbus_size=0, sbus_addr=0, sbus_wdata=0, state IDLE, sbaddress0=0, sbdata0=0, sbaccess=2, sbautoincrement=0, sbreadonaddr=0, sbreadondata=0, sberror=0, sbbusyerror=0.
- sbcs read layout:
  - [31:29] sbversion=1; [22] sbbusyerror; [21] sbbusy; [20] sbreadonaddr; [19:17] sbaccess; [16] sbautoincrement; [15] sbreadondata; [14:12] sberror.
  - [11:5] sbasize=W_ADDR; [2:0] sbaccess32/16/8=3'b111; all other bits 0.
- sbcs write: sbbusyerror and sberror are write-1-to-clear; remaining RW fields written directly.
- FSM has two states:
  - IDLE: sbbusy=0.
  - BUS: sbbusy=1, sbus_vld=1; sbus_addr, sbus_write, sbus_size, sbus_wdata come from registers latched at entry.
- Trigger events:
  - write sbdata0 -> write access;
  - write sbaddress0 with sbreadonaddr=1 -> read access;
  - read sbdata0 with sbreadondata=1 -> read access, issued after the current sbdata0 value is returned.
- Trigger rules:
  - Any trigger, or any sbaddress0/sbdata0 write or sbdata0 read, while sbbusy=1 sets sbbusyerror. The register is not modified and no access starts.
  - Triggers are ignored (no access) while sberror!=0 or sbbusyerror=1; register writes still take effect.
- Pre-issue checks, in this order; on failure the FSM stays in IDLE:
  - sbaccess>2 -> sberror=4;
  - address misaligned to 1<<sbaccess -> sberror=3.
- Otherwise IDLE->BUS on the next edge; sbus_vld is asserted from the cycle after the trigger.
- sbus_vld stays high until the cycle sbus_rdy=1 is sampled, then BUS->IDLE; sbus_vld=0 the following cycle. Never deassert earlier: the arbiter may already hold the grant.
- Completion is the cycle with sbus_rdy=1:
  - sbus_err=1 in that cycle -> sberror=2; no sbdata0 update; no autoincrement.
  - Otherwise a read right-justifies: sbdata0 = (sbus_rdata >> 8*addr[1:0]) masked to 8/16/32 bits.
  - Otherwise, if sbautoincrement=1, sbaddress0 += (1<<sbaccess), wrapping modulo 2^W_ADDR.
- An sbus_err with sbus_rdy=0 (first cycle of a two-cycle error) is ignored; only the rdy cycle counts.
- Write data is replicated: byte -> {4{b}}, half -> {2{h}}.
- A register access in the same cycle as completion still sees sbbusy=1 and sets sbbusyerror.
- dmactive=0: all registers return to reset values. If in BUS, sbus_vld and the latched request are held until sbus_rdy, then the result is discarded. New accesses are blocked until dmactive=1.
- rst_n mid-transfer: immediate return to IDLE. The surrounding bus is reset on the same rst_n.

Decomposition:
- Package hazard3_sba_pkg holds:
  - register indices;
  - sbcs bit positions;
  - sberror codes (0 none, 2 bus error, 3 alignment, 4 size);
  - sbversion constant.
- One natural sub-module, hazard3_sbus_lanes (combinational): write-data replication and read-data extract/mask by size and addr[1:0].

Test Plan:
- sbaccess=2; write sbaddress0=0x2000_0004; write sbdata0=0xDEADBEEF -> one transfer: vld 1 cycle later, addr 0x20000004, write=1, size=2, wdata 0xDEADBEEF; sbbusy drops the cycle after rdy.
- sbaccess=0, sbreadonaddr=1; write sbaddress0=0x103; bus returns 0xAABBCCDD -> sbdata0 reads 0x000000AA.
- sbaccess=1, autoincrement=1; three sbdata0 writes of 0x1234 from 0x1000 -> addresses 0x1000, 0x1002, 0x1004; wdata 0x12341234; sbaddress0 ends at 0x1006.
- Misaligned halfword at 0x1001 -> sberror=3, no vld. sbaccess=5 -> sberror=4. Bus returns err+rdy -> sberror=2, sbaddress0 unchanged. W1C 0x7000 to sbcs clears sberror.
- sbdata0 write while sbbusy=1 with rdy stalled 5 cycles -> sbbusyerror=1, sbdata0 unchanged, only one transfer on bus.
- dmactive dropped mid-transfer with rdy held low 3 cycles -> vld stays high until rdy, then 0. sbcs reads reset values; a read result does not reach sbdata0.
